cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder; next generation of the cla32 adder.
//  Operands split into STAGES equal slices; each slice is added by GROUP-bit CLA blocks.
//  Slice carry is registered between stages; operands and sums are skewed through the pipeline.
//  Valid/ready on both sides: one add accepted per cycle, full backpressure.
// PARAMETERS
//  WIDTH   32  operand/sum width in bits
//  GROUP    4  CLA group width (generate/propagate block size)
//  STAGES   2  pipeline stages = latency in cycles; WIDTH % (STAGES*GROUP) must be 0
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      a/b/cin valid this cycle
//  in_ready   out  1      adder accepts input this cycle
//  a          in   WIDTH  operand A (unsigned; two's complement with the OVF option)
//  b          in   WIDTH  operand B
//  cin        in   1      carry in
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow (only with CLA_PIPE_OVF_EN)
// BEHAVIOUR
//  - Slice width SW = WIDTH/STAGES. Stage k adds bits [k*SW +: SW] using the carry registered by stage k-1.
//    Stage 0 uses cin.
//  - Within a slice: GROUP-bit g/p blocks with a lookahead carry chain between groups.
//    No ripple across a full slice.
//  - Each stage holds a valid bit, the remaining upper operand bits, the accumulated lower sum bits,
//    and its carry.
//  - Advance: adv = ~out_valid | out_ready. The whole pipeline shifts only when adv is 1.
//    in_ready = adv, combinational from out_ready and out_valid.
//  - Transfer: in-side when in_valid & in_ready; out-side when out_valid & out_ready.
//  - Latency: an input accepted at edge N gives out_valid=1 after edge N+STAGES-1,
//    when there is no stall. Throughput is 1 result per cycle.
//  - Stall (out_valid=1, out_ready=0):
//    - All stage registers hold, including bubbles.
//    - in_ready=0.
//    - sum, cout, ovf and out_valid stay stable until accepted.
//  - Bubbles: in_valid=0 on an advancing cycle inserts valid=0 into stage 0.
//    Bubbles are not collapsed.
//  - Simultaneous accept and deliver on one edge is legal; the pipeline shifts by one.
//  - Arithmetic: cout = bit WIDTH of the (WIDTH+1)-bit result.
//    All-ones + 0 + cin=1 gives sum=0, cout=1 (full carry propagation across every slice).
//  - Reset (rst=1 at an edge):
//    - Every stage valid bit clears; out_valid=0.
//    - sum, cout and ovf are 0; all data registers are 0.
//    - Reset mid-operation discards in-flight adds with no output.
//    - While rst=1, in_ready=1 and nothing is captured.
//  - Data registers of invalid stages may update freely.
//    Outputs are only meaningful while out_valid=1, except for the reset value.
// CONFIGURATION
//  - CLA_PIPE_OVF_EN defined:
//    - Port ovf is present.
//    - ovf = (a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1]).
//    - Operand MSBs are carried to the last stage; ovf is aligned with sum and is 0 on reset.
//  - CLA_PIPE_OVF_EN undefined: port ovf and its pipeline bits are absent. Other behaviour is identical.
// TESTING (WIDTH=32, GROUP=4, STAGES=2 unless noted)
//  1. a=FFFFFFFF, b=0, cin=1, out_ready=1.
//     -> out_valid after 2 edges: sum=00000000, cout=1. With OVF: ovf=0.
//  2. a=7FFFFFFF, b=00000001, cin=0.
//     -> sum=80000000, cout=0. With OVF: ovf=1.
//  3. Back-to-back inputs (1,2,0), (FFFF0000,0000FFFF,1), (80000000,80000000,0), in_valid held high.
//     -> consecutive outputs 00000003/0, 00000000/1, 00000000/1, one per cycle, in order.
//  4. out_ready=0 for 5 cycles with 2 adds in flight.
//     -> in_ready=0; sum/out_valid stable; both results delivered in order once out_ready=1;
//        none lost or duplicated.
//  5. rst=1 for one edge while 2 adds are in flight.
//     -> out_valid=0, sum=0, cout=0 next cycle; no stale result appears afterwards.
//  6. Repeat 1-3 with WIDTH=64, GROUP=4, STAGES=4.
//     -> latency 4; 64-bit all-ones + 1 gives sum=0, cout=1.

Source files
------------

// File: rtl/cla_pipe_adder_if.sv
// Valid/ready bus of cla_pipe_adder. The ovf signal exists only when
// CLA_PIPE_OVF_EN is defined.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_PIPE_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef CLA_PIPE_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef CLA_PIPE_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: STAGES slices of GROUP-bit CLA blocks, one slice per stage,
// valid/ready with full backpressure. Define CLA_PIPE_OVF_EN to add the signed-overflow output.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  cla_pipe_adder_if.slave  bus
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / GROUP;

  if (WIDTH % (STAGES * GROUP) != 0) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*GROUP");
  end

  // Group generate/propagate feed a lookahead chain across groups; bits inside a group
  // only see their own group carry-in.
  function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                            input logic ci);
    logic [SW-1:0] g, p, s;
    logic [NG:0]   gc;
    logic          gg, gp, c;
    g     = x & y;
    p     = x ^ y;
    s     = '0;
    gc    = '0;
    gc[0] = ci;
    for (int j = 0; j < NG; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
        gp = gp & p[j*GROUP+i];
      end
      gc[j+1] = gg | (gp & gc[j]);
    end
    for (int j = 0; j < NG; j++) begin
      c = gc[j];
      for (int i = 0; i < GROUP; i++) begin
        s[j*GROUP+i] = p[j*GROUP+i] ^ c;
        c = g[j*GROUP+i] | (p[j*GROUP+i] & c);
      end
    end
    return {gc[NG], s};
  endfunction

  logic [STAGES-1:0] vld_q, co_q, ci, vin;
  logic [WIDTH-1:0]  ra_q   [STAGES];
  logic [WIDTH-1:0]  rb_q   [STAGES];
  logic [WIDTH-1:0]  acc_q  [STAGES];
  logic [WIDTH-1:0]  ra_in  [STAGES];
  logic [WIDTH-1:0]  rb_in  [STAGES];
  logic [WIDTH-1:0]  acc_in [STAGES];
  logic [WIDTH-1:0]  acc_nx [STAGES];
  logic [SW-1:0]     xa     [STAGES];
  logic [SW-1:0]     xb     [STAGES];
  logic [SW:0]       slice  [STAGES];
  logic              adv;

  assign adv          = ~vld_q[STAGES-1] | bus.out_ready;
  assign bus.in_ready = rst | adv;

  // Remaining operand bits travel shifted down so each stage always adds the low SW bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign ra_in[k]  = bus.a;
      assign rb_in[k]  = bus.b;
      assign acc_in[k] = '0;
      assign ci[k]     = bus.cin;
      assign vin[k]    = bus.in_valid;
    end else begin : g_body
      assign ra_in[k]  = ra_q[k-1];
      assign rb_in[k]  = rb_q[k-1];
      assign acc_in[k] = acc_q[k-1];
      assign ci[k]     = co_q[k-1];
      assign vin[k]    = vld_q[k-1];
    end
    assign xa[k]     = ra_in[k][SW-1:0];
    assign xb[k]     = rb_in[k][SW-1:0];
    assign slice[k]  = cla_slice(xa[k], xb[k], ci[k]);
    assign acc_nx[k] = acc_in[k] | (WIDTH'(slice[k][SW-1:0]) << (k * SW));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      co_q  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ra_q[k]  <= '0;
        rb_q[k]  <= '0;
        acc_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= vin;
      for (int k = 0; k < STAGES; k++) begin
        co_q[k]  <= slice[k][SW];
        ra_q[k]  <= ra_in[k] >> SW;
        rb_q[k]  <= rb_in[k] >> SW;
        acc_q[k] <= acc_nx[k];
      end
    end
  end

`ifdef CLA_PIPE_OVF_EN
  logic ovf_q, ovf_d;
  // Operand MSBs reach the last stage inside its slice, so ovf registers alongside sum.
  assign ovf_d = (xa[STAGES-1][SW-1] == xb[STAGES-1][SW-1]) &
                 (slice[STAGES-1][SW-1] != xa[STAGES-1][SW-1]);

  always_ff @(posedge clk) begin
    if (rst)      ovf_q <= 1'b0;
    else if (adv) ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = acc_q[STAGES-1];
  assign bus.cout      = co_q[STAGES-1];
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: a 32/4/2 and a 64/4/4 instance driven with
// directed vectors; monitors pop expected results whenever a result is handed over.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(32)) i32 ();
  cla_pipe_adder_if #(.WIDTH(64)) i64 ();

  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(2)) u32 (.clk(clk), .rst(rst), .bus(i32.slave));
  cla_pipe_adder #(.WIDTH(64), .GROUP(4), .STAGES(4)) u64 (.clk(clk), .rst(rst), .bus(i64.slave));

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  int   checks = 0;
  int   failures = 0;
  int   n_out32 = 0;
  int   n_out64 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  always @(negedge clk) begin
    if (!rst && i32.out_valid && i32.out_ready) begin
      if (q32.size() == 0) timeout("out32_unexpected_result");
      else begin
        e32 = q32.pop_front();
        check("sum32", {32'h0, i32.sum}, e32.s);
        check("cout32", 64'(i32.cout), 64'(e32.c));
`ifdef CLA_PIPE_OVF_EN
        check("ovf32", 64'(i32.ovf), 64'(e32.o));
`endif
        n_out32++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && i64.out_valid && i64.out_ready) begin
      if (q64.size() == 0) timeout("out64_unexpected_result");
      else begin
        e64 = q64.pop_front();
        check("sum64", i64.sum, e64.s);
        check("cout64", 64'(i64.cout), 64'(e64.c));
`ifdef CLA_PIPE_OVF_EN
        check("ovf64", 64'(i64.ovf), 64'(e64.o));
`endif
        n_out64++;
      end
    end
  end

  function automatic logic dvalid(input bit w);
    return w ? i64.out_valid : i32.out_valid;
  endfunction
  function automatic logic dready(input bit w);
    return w ? i64.in_ready : i32.in_ready;
  endfunction
  function automatic logic [63:0] dsum(input bit w);
    return w ? i64.sum : {32'h0, i32.sum};
  endfunction
  function automatic logic dcout(input bit w);
    return w ? i64.cout : i32.cout;
  endfunction
  function automatic int dnout(input bit w);
    return w ? n_out64 : n_out32;
  endfunction

  task automatic drive(input bit w, input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic c);
    if (w) begin
      i64.in_valid = v; i64.a = a; i64.b = b; i64.cin = c;
    end else begin
      i32.in_valid = v; i32.a = a[31:0]; i32.b = b[31:0]; i32.cin = c;
    end
  endtask

  task automatic set_ready(input bit w, input logic v);
    if (w) i64.out_ready = v;
    else   i32.out_ready = v;
  endtask

  task automatic send(input bit w, input logic [63:0] a, input logic [63:0] b, input logic c,
                      input logic [63:0] es, input logic ec, input logic eo);
    int t = 0;
    drive(w, 1'b1, a, b, c);
    @(negedge clk);
    while (!dready(w) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      timeout("send_in_ready");
      drive(w, 1'b0, '0, '0, 1'b0);
      return;
    end
    if (w) q64.push_back('{es, ec, eo});
    else   q32.push_back('{es, ec, eo});
    @(posedge clk);
    #1;
    drive(w, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit w, output int cnt);
    cnt = 0;
    while (!dvalid(w) && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (cnt >= 20) timeout("wait_out_valid");
  endtask

  task automatic run(input bit w);
    logic [63:0] ones = w ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    logic [63:0] msb  = w ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    logic [63:0] hi   = w ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_0000;
    logic [63:0] lo   = w ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
    logic [63:0] sa   = w ? 64'h1234_5678_9ABC_DEF0 : 64'h0000_0000_1234_5678;
    logic [63:0] sb   = w ? 64'h1111_1111_1111_1111 : 64'h0000_0000_1111_1111;
    logic [63:0] ss   = w ? 64'h2345_6789_ABCD_F001 : 64'h0000_0000_2345_6789;
    logic [63:0] ta   = w ? 64'hF000_0000_0000_0000 : 64'h0000_0000_F000_0000;
    logic [63:0] tb   = w ? 64'h2000_0000_0000_0000 : 64'h0000_0000_2000_0000;
    logic [63:0] ts   = w ? 64'h1000_0000_0000_0001 : 64'h0000_0000_1000_0001;
    int lat_exp = w ? 3 : 1;
    int cnt, base;

    // all-ones + 0 + 1, plus first-result latency
    send(w, ones, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
    wait_valid(w, cnt);
    check(w ? "latency64" : "latency32", 64'(cnt), 64'(lat_exp));
    idle(10);

    send(w, msb - 64'h1, 64'h1, 1'b0, msb, 1'b0, 1'b1);
    send(w, 64'h0000_FFFF, 64'h1, 1'b0, 64'h0001_0000, 1'b0, 1'b0);
    idle(10);

    // back-to-back burst, one result per cycle
    base = dnout(w);
    send(w, 64'h1, 64'h2, 1'b0, 64'h3, 1'b0, 1'b0);
    send(w, hi, lo, 1'b1, 64'h0, 1'b1, 1'b0);
    send(w, msb, msb, 1'b0, 64'h0, 1'b1, 1'b1);
    idle(lat_exp + 1);
    check(w ? "burst_rate64" : "burst_rate32", 64'(dnout(w) - base), 64'd3);
    idle(10);

    // backpressure with two adds in flight
    set_ready(w, 1'b0);
    base = dnout(w);
    send(w, sa, sb, 1'b0, ss, 1'b0, 1'b0);
    send(w, ta, tb, 1'b1, ts, 1'b1, 1'b0);
    wait_valid(w, cnt);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", 64'(dready(w)), 64'd0);
      check("stall_out_valid", 64'(dvalid(w)), 64'd1);
      check("stall_sum", dsum(w), ss);
    end
    check("stall_none_delivered", 64'(dnout(w) - base), 64'd0);
    set_ready(w, 1'b1);
    idle(10);
    check("stall_delivered", 64'(dnout(w) - base), 64'd2);

    // reset with two adds in flight; input offered during reset must be ignored
    set_ready(w, 1'b0);
    send(w, 64'h5, 64'h6, 1'b0, 64'hB, 1'b0, 1'b0);
    send(w, 64'h7, 64'h8, 1'b1, 64'h10, 1'b0, 1'b0);
    idle(2);
    rst = 1'b1;
    drive(w, 1'b1, 64'hAAAA, 64'h5555, 1'b1);
    #1;
    check("rst_in_ready", 64'(dready(w)), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(w, 1'b0, '0, '0, 1'b0);
    check("rst_out_valid", 64'(dvalid(w)), 64'd0);
    check("rst_sum", dsum(w), 64'h0);
    check("rst_cout", 64'(dcout(w)), 64'd0);
`ifdef CLA_PIPE_OVF_EN
    check("rst_ovf", 64'(w ? i64.ovf : i32.ovf), 64'd0);
`endif
    if (w) q64.delete();
    else   q32.delete();
    base = dnout(w);
    set_ready(w, 1'b1);
    idle(10);
    check("rst_no_stale", 64'(dnout(w) - base), 64'd0);

    send(w, 64'h3, 64'h4, 1'b1, 64'h8, 1'b0, 1'b0);
    idle(10);
    check("post_rst_delivered", 64'(dnout(w) - base), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0);
    set_ready(1'b0, 1'b1);
    set_ready(1'b1, 1'b1);
    idle(3);
    for (int w = 0; w < 2; w++) begin
      check("reset_out_valid", 64'(dvalid(w[0])), 64'd0);
      check("reset_sum", dsum(w[0]), 64'h0);
      check("reset_cout", 64'(dcout(w[0])), 64'd0);
      check("reset_in_ready", 64'(dready(w[0])), 64'd1);
    end
    rst = 1'b0;
    idle(2);

    run(1'b0);
    run(1'b1);

    check("queue32_empty", 64'(q32.size()), 64'd0);
    check("queue64_empty", 64'(q64.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
